// File: rtl/seg_scan_ctrl.sv
// Purpose : time-multiplexed scan of DIGITS nibbles onto one shared seven-segment decoder.
// Latency : outputs registered; first blank slot is visible one edge after en is sampled high.
// Backpressure: none; free-running scan, value updates held in a shadow until a frame boundary.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking (digit 0 always lit).
module seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            data,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    // One counter serves both slot types, so it is sized for the longer one.
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_n;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_n;
    logic                  commit;
    logic                  frame_done_n;

    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   shadow_n;
    logic [4*DIGITS-1:0]   display;
    logic [4*DIGITS-1:0]   display_n;
    logic                  pending;
    logic                  pending_n;

    logic [4*DIGITS-1:0]   shifted;
    logic [DIGITS-1:0]     sel_onehot;
    logic [DIGITS-1:0]     lit_mask;
    logic [3:0]            data_n;
    logic [DIGITS-1:0]     digit_sel_n;

    // Scan sequencing: IDLE -> (BLANK -> SHOW) per digit, commit at frame start.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        commit       = 1'b0;
        frame_done_n = 1'b0;
        if (!en) begin
            // Dropping en abandons the frame: no commit, no frame_done.
            state_n = S_IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_BLANK;
                    idx_n   = '0;
                    cnt_n   = '0;
                    commit  = 1'b1;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = S_SHOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_n = S_BLANK;
                        cnt_n   = '0;
                        if (idx == IDX_LAST) begin
                            idx_n        = '0;
                            commit       = 1'b1;
                            frame_done_n = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Shadow/display handoff; a load on a commit edge bypasses the shadow.
    always_comb begin
        shadow_n  = shadow;
        display_n = display;
        pending_n = pending;
        if (load) begin
            shadow_n  = value;
            pending_n = 1'b1;
        end
        if (commit) begin
            display_n = load ? value : shadow;
            pending_n = 1'b0;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic nz_above;

    // A digit is lit if it or any more significant nibble is non-zero; digit 0 always lit.
    always_comb begin
        lit_mask = '0;
        nz_above = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_above    = nz_above | (display_n[4*k +: 4] != 4'd0);
            lit_mask[k] = nz_above | (k == 0);
        end
    end
`else
    assign lit_mask = '1;
`endif

    // Output decode from next-cycle state so data/digit_sel/frame_done are plain flops.
    always_comb begin
        shifted     = display_n >> {idx_n, 2'b00};
        sel_onehot  = {{(DIGITS-1){1'b0}}, 1'b1} << idx_n;
        data_n      = 4'd0;
        digit_sel_n = '0;
        case (state_n)
            S_BLANK: begin
                data_n = shifted[3:0];
            end
            S_SHOW: begin
                data_n = shifted[3:0];
                if (lit_mask[idx_n]) begin
                    digit_sel_n = sel_onehot;
                end
            end
            default: begin
                data_n      = 4'd0;
                digit_sel_n = '0;
            end
        endcase
    end

    // Control state; reset drops everything immediately, including display contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Value storage: shadow collects loads, display is what the current frame shows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            shadow  <= shadow_n;
            display <= display_n;
            pending <= pending_n;
        end
    end

    // Registered outputs toward the decoder and digit drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= 4'd0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            data       <= data_n;
            digit_sel  <= digit_sel_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
// Per-cycle vector table with expected outputs, plus hand-written reset sequences.
module tb_seg_scan_ctrl;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int SLOT         = BLANK_CYCLES + PRESCALE;
    localparam int FRAME        = DIGITS * SLOT;
    localparam int RESET_ROW    = 124;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  data;
    logic [3:0]  digit_sel;
    logic        frame_done;

    typedef struct packed {
        logic        en;
        logic        load;
        logic [15:0] value;
        logic [3:0]  data;
        logic [3:0]  sel;
        logic        fd;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seg_scan_ctrl #(
        .DIGITS(DIGITS),
        .PRESCALE(PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .load(load),
        .value(value),
        .data(data),
        .digit_sel(digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int slot);
        logic [15:0] t;
        t = v >> (4 * slot);
        return t[3:0];
    endfunction

    function automatic logic [3:0] exp_sel(input logic [15:0] v, input int slot);
        logic [3:0]  s;
        logic [15:0] t;
        s = 4'b0001 << slot;
        t = v >> (4 * slot);
`ifdef SEG_SCAN_LZB_EN
        if (slot != 0 && t == 16'h0000) s = 4'b0000;
`endif
        return s;
    endfunction

    function automatic vec_t mk(input logic e, input logic l, input logic [15:0] v,
                                input logic [3:0] d, input logic [3:0] s, input logic f);
        vec_t r;
        r.en = e; r.load = l; r.value = v; r.data = d; r.sel = s; r.fd = f;
        return r;
    endfunction

    // Expected outputs at offset k of a frame showing v.
    function automatic vec_t frame_row(input logic [15:0] v, input int k, input logic fd_first);
        int slot;
        int off;
        slot = k / SLOT;
        off  = k % SLOT;
        return mk(1'b1, 1'b0, 16'h0000, nib(v, slot),
                  (off < BLANK_CYCLES) ? 4'b0000 : exp_sel(v, slot),
                  (k == 0) ? fd_first : 1'b0);
    endfunction

    task automatic push_rows(input logic [15:0] v, input int n, input logic fd_first);
        for (int k = 0; k < n; k++) tbl.push_back(frame_row(v, k, fd_first));
    endtask

    task automatic set_load(input int i, input logic [15:0] v);
        vec_t r;
        r = tbl[i];
        r.load  = 1'b1;
        r.value = v;
        tbl[i]  = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Rows 0..99: scenarios 1-3 (load+enable, mid-frame load, boundary load).
        push_rows(16'h1234, FRAME, 1'b0);
        push_rows(16'h1234, FRAME, 1'b1);
        push_rows(16'h5678, FRAME, 1'b1);
        push_rows(16'hABCD, FRAME, 1'b1);
        push_rows(16'hABCD, FRAME, 1'b1);
        // Rows 100..112: into digit 2 SHOW slot; rows 113..115 en low.
        push_rows(16'hABCD, 13, 1'b1);
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1'b0, 1'b0, 16'h0, 4'h0, 4'b0000, 1'b0));
        // Rows 116..123: re-enable, ends mid-SHOW of digit 1.
        push_rows(16'hABCD, 8, 1'b0);
        // Rows 124..183: after reset, zero frame, then leading-zero cases.
        push_rows(16'h0000, FRAME, 1'b0);
        push_rows(16'h0070, FRAME, 1'b1);
        push_rows(16'h0000, FRAME, 1'b1);

        set_load(0,   16'h1234);
        set_load(22,  16'h9999);
        set_load(27,  16'h5678);
        set_load(60,  16'hABCD);
        set_load(144, 16'h0070);
        set_load(164, 16'h0000);

        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        value = 16'h0000;
        @(posedge clk);
        #1;
        check("reset data", {12'h0, data}, 16'h0);
        check("reset digit_sel", {12'h0, digit_sel}, 16'h0);
        check("reset frame_done", {15'h0, frame_done}, 16'h0);
        check("reset pending", {15'h0, dut.pending}, 16'h0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == RESET_ROW) begin
                // Asynchronous reset in the middle of a lit SHOW slot.
                #1 reset = 1'b1;
                #1;
                check("async reset data", {12'h0, data}, 16'h0);
                check("async reset digit_sel", {12'h0, digit_sel}, 16'h0);
                check("async reset frame_done", {15'h0, frame_done}, 16'h0);
                check("async reset display", dut.display, 16'h0);
                #2 reset = 1'b0;
            end
            en    = tbl[i].en;
            load  = tbl[i].load;
            value = tbl[i].value;
            @(posedge clk);
            #1;
            check($sformatf("row%0d data", i), {12'h0, data}, {12'h0, tbl[i].data});
            check($sformatf("row%0d digit_sel", i), {12'h0, digit_sel}, {12'h0, tbl[i].sel});
            check($sformatf("row%0d frame_done", i), {15'h0, frame_done}, {15'h0, tbl[i].fd});
            if (i == 0 || i == 40 || i == 60 || i == 144)
                check($sformatf("row%0d pending clear", i), {15'h0, dut.pending}, 16'h0);
            if (i == 22 || i == 27)
                check($sformatf("row%0d pending set", i), {15'h0, dut.pending}, 16'h1);
        end
        load = 1'b0;
        en   = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller that shares a single seven-segment decoder among DIGITS common-anode/cathode digit positions. It latches a packed BCD/hex value, steps through the digits in a fixed round-robin order, presents one nibble at a time to the downstream `sevenseg` decoder, and drives a one-hot digit enable. Blank (dead) cycles between digits prevent ghosting. Value updates are applied only at frame boundaries, so a frame never shows mixed digits.

## Interface
- DIGITS, 4: number of digit positions, ≥2.
- PRESCALE, 1000: clk cycles each digit is lit (SHOW), ≥1.
- BLANK_CYCLES, 2: clk cycles with all digits off before each digit (BLANK), ≥1.

- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- en  input  1  scan enable; low forces IDLE.
- load  input  1  single-cycle strobe; captures `value` into the shadow register.
- value  input  4*DIGITS  packed nibbles; [3:0] = digit 0 (least significant).
- data  output  4  nibble for the sevenseg decoder (registered).
- digit_sel  output  DIGITS  one-hot digit enable, active-high (registered).
- frame_done  output  1  one-cycle pulse per completed frame (registered).

## Operation
- Registers: shadow[4*DIGITS], display[4*DIGITS], pending, digit index idx, slot counter cnt, and state.
- load: shadow <= value, pending <= 1. A load while pending is already set overwrites shadow.
- Commit: display <= shadow, pending <= 0. Commit occurs on the IDLE->BLANK transition and at each frame boundary. If load coincides with a commit, display takes `value` directly and pending stays 0.
- States:
  - IDLE: digit_sel = 0, data = 0, idx = 0. Leave for BLANK when en = 1.
  - BLANK: digit_sel = 0, data = display nibble[idx]. Lasts BLANK_CYCLES, then goes to SHOW.
  - SHOW: digit_sel = 1<<idx, data = display nibble[idx]. Lasts PRESCALE.
    - On its last cycle with idx < DIGITS-1: idx++, go to BLANK.
    - On its last cycle with idx = DIGITS-1: idx <= 0, go to BLANK, commit, and pulse frame_done.
- en = 0 in any state: IDLE on the next edge. The frame is abandoned, with no frame_done and no commit.
- cnt width is clog2(max(PRESCALE, BLANK_CYCLES)). idx width is clog2(DIGITS). Neither counter exceeds its terminal value.

## Timing
- Reset values: data = 0, digit_sel = 0, frame_done = 0. State IDLE; idx, cnt, shadow, display and pending all 0.
- Reset is asynchronous and takes effect mid-operation. All outputs drop immediately and the display contents are lost.
- Cycle N samples en = 1 in IDLE. Cycles N+1 .. N+BLANK_CYCLES are BLANK for digit 0. SHOW for digit 0 follows for PRESCALE cycles.
- Frame period: DIGITS*(BLANK_CYCLES+PRESCALE) cycles.
- frame_done is high during the first BLANK cycle of the next frame. display is updated on the same edge.
- digit_sel is never multi-hot. A change of lit digit always passes through at least BLANK_CYCLES of digit_sel = 0.
- data changes only on BLANK entry, never inside a SHOW slot.

## Configuration
- SEG_SCAN_LZB_EN, leading-zero blanking.
  - Defined: in any SHOW slot for idx ≥ 1, digit_sel stays 0 if nibble[idx] and every more significant nibble are 0. Slot timing and data output are unchanged. Digit 0 is always lit, so value 0 shows a single "0".
  - Undefined: every digit is lit in its slot.

## Test plan
Bench parameters: DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
1. Load with enable: reset, then load = 1 with value = 16'h1234 and en = 1 in the same cycle.
   - Required: 1 blank cycle, then data = 4 and digit_sel = 0001 for 4 cycles. Then 3/0010, 2/0100, 1/1000, each preceded by one cycle of digit_sel = 0.
   - Required: frame_done every 20 cycles.
2. Mid-frame load: load 16'h5678 during the digit 1 SHOW slot.
   - Required: the rest of the frame still shows 3, 2, 1.
   - Required: the next frame shows 8, 7, 6, 5, and the change aligns with frame_done.
3. Load at the boundary: assert load with 16'hABCD on the last SHOW cycle of digit 3.
   - Required: the next frame shows D, C, B, A.
   - Required: pending = 0, and no extra update at the following boundary.
4. Disable mid-scan: drop en during the digit 2 SHOW slot.
   - Required: next cycle digit_sel = 0, data = 0, and no frame_done.
   - Required: on re-enable, the first lit digit is digit 0 after 1 blank cycle.
5. Reset mid-scan: assert reset asynchronously mid-SHOW.
   - Required: data, digit_sel and frame_done go to 0 before the next clock edge.
   - Required: after release with en = 1 and no load, all digits show 0.
6. Leading-zero blanking: value 16'h0070.
   - With SEG_SCAN_LZB_EN: digit_sel is 0 in the slots for digits 3 and 2. Digits 1 and 0 are lit with data 7 and 0.
   - Without the macro: all four digits are lit.
   - With the macro and value 16'h0000: only digit 0 is lit.
